// File: rtl/systolic_output_collector.sv
// Collects a framed window of systolic-array outputs into a show-ahead FIFO.
// Optional ReLU on captured samples: define SYSTOLIC_COLLECTOR_RELU_EN.
module systolic_output_collector #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned SKIP_COUNT      = 2,
    parameter int unsigned FRAME_LEN       = 14,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned FIFO_ADDR_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       ce,
    input  logic signed [WIDTH-1:0]    y_in,
    output logic signed [WIDTH-1:0]    out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       overflow,
    output logic [FIFO_ADDR_WIDTH:0]   level
);

    localparam int unsigned SKIP_W = (SKIP_COUNT > 1) ? $clog2(SKIP_COUNT) : 1;
    localparam int unsigned CAP_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP_COUNT > 0) ? SKIP_COUNT - 1 : 0);
    localparam logic [CAP_W-1:0]  CAP_LAST  = CAP_W'((FRAME_LEN > 0) ? FRAME_LEN - 1 : 0);
    localparam logic [FIFO_ADDR_WIDTH:0] FULL_LEVEL = (FIFO_ADDR_WIDTH + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        CAPTURE
    } state_t;

    state_t                       state;
    logic [SKIP_W-1:0]            skip_cnt;
    logic [CAP_W-1:0]             cap_cnt;

    logic signed [WIDTH-1:0]      mem [FIFO_DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0]   wr_ptr;
    logic [FIFO_ADDR_WIDTH-1:0]   rd_ptr;
    logic [FIFO_ADDR_WIDTH:0]     count;

    logic                         take;
    logic                         fifo_full;
    logic                         push;
    logic                         pop;
    logic signed [WIDTH-1:0]      wr_data;

    assign take      = ce && (state == CAPTURE);
    assign fifo_full = (count == FULL_LEVEL);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts the write when the head leaves on the same edge.
    assign push      = take && (!fifo_full || pop);
    assign level     = count;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

`ifdef SYSTOLIC_COLLECTOR_RELU_EN
    always_comb begin
        wr_data = y_in;
        if (y_in[WIDTH-1]) begin
            wr_data = '0;
        end
    end
`else
    always_comb begin
        wr_data = y_in;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            skip_cnt   <= '0;
            cap_cnt    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (take && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        overflow <= 1'b0;
                        skip_cnt <= '0;
                        cap_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= (SKIP_COUNT == 0) ? CAPTURE : SKIP;
                    end
                end
                SKIP: begin
                    if (ce) begin
                        if (skip_cnt == SKIP_LAST) begin
                            skip_cnt <= '0;
                            state    <= CAPTURE;
                        end else begin
                            skip_cnt <= skip_cnt + 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    // Dropped samples still advance the frame count.
                    if (ce) begin
                        if (cap_cnt == CAP_LAST) begin
                            cap_cnt    <= '0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            cap_cnt <= cap_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_output_collector.sv
// Randomized scoreboard bench for systolic_output_collector with a small-FIFO configuration.
module tb_systolic_output_collector;

    localparam int W  = 8;
    localparam int SK = 2;
    localparam int FL = 6;
    localparam int D  = 4;
    localparam int AW = 2;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic                 ce;
    logic signed [W-1:0]  y_in;
    logic signed [W-1:0]  out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic                 frame_done;
    logic                 overflow;
    logic [AW:0]          level;

    systolic_output_collector #(
        .WIDTH(W),
        .SKIP_COUNT(SK),
        .FRAME_LEN(FL),
        .FIFO_DEPTH(D),
        .FIFO_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .ce(ce),
        .y_in(y_in),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .frame_done(frame_done),
        .overflow(overflow),
        .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned passes = 0;

    // Reference model: a frame is a run of SK + FL taken samples after start;
    // the FIFO is just an occupancy count plus the queue of expected outputs.
    int                   m_cnt    = 0;
    int                   m_taken  = 0;
    bit                   m_active = 0;
    bit                   m_done   = 0;
    bit                   m_ovf    = 0;
    logic signed [W-1:0]  sb_q[$];
    logic signed [W-1:0]  tbl[5] = '{-8'sd3, 8'sd0, 8'sd4, -8'sd128, 8'sd127};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic logic signed [W-1:0] stored_value(input logic signed [W-1:0] v);
`ifdef SYSTOLIC_COLLECTOR_RELU_EN
        return (v < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic model_step();
        bit pop_m;
        bit push_m;
        if (!rst_n) begin
            m_cnt = 0; m_taken = 0; m_active = 0; m_done = 0; m_ovf = 0;
            sb_q.delete();
            return;
        end
        pop_m  = (m_cnt > 0) && out_ready;
        push_m = 0;
        m_done = 0;
        if (!m_active) begin
            if (start) begin
                m_active = 1; m_taken = 0; m_ovf = 0;
            end
        end else if (ce) begin
            if (m_taken >= SK) begin
                if (m_cnt < D || pop_m) begin
                    push_m = 1;
                    sb_q.push_back(stored_value(y_in));
                end else begin
                    m_ovf = 1;
                end
            end
            m_taken++;
            if (m_taken == SK + FL) begin
                m_active = 0;
                m_done   = 1;
            end
        end
        m_cnt = m_cnt + int'(push_m) - int'(pop_m);
    endtask

    task automatic check_outputs();
        check("level", int'(level), m_cnt);
        check("out_valid", int'(out_valid), int'(m_cnt > 0));
        check("busy", int'(busy), int'(m_active));
        check("frame_done", int'(frame_done), int'(m_done));
        check("overflow", int'(overflow), int'(m_ovf));
    endtask

    // Monitor: every accepted output is compared with the oldest expected sample.
    initial begin
        logic signed [W-1:0] exp_v;
        forever begin
            @(negedge clk);
            #2;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    $display("FAIL out_data: got %0d expected nothing (scoreboard empty) at %0t",
                             out_data, $time);
                end else begin
                    exp_v = sb_q.pop_front();
                    check("out_data", int'(out_data), int'(exp_v));
                end
            end
        end
    end

    initial begin
        int ready_pct;
        int ce_pct;
        int start_pct;
        rst_n = 1'b0; start = 1'b0; ce = 1'b0; y_in = '0; out_ready = 1'b0;
        ready_pct = 100; ce_pct = 100; start_pct = 100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_data", int'(out_data), 0);
        check_outputs();
        #1;
        rst_n = 1'b1;
        model_step();

        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 250 == 0) begin
                case ($urandom_range(0, 3))
                    0: ready_pct = 0;
                    1: ready_pct = 30;
                    2: ready_pct = 70;
                    default: ready_pct = 100;
                endcase
                case ($urandom_range(0, 2))
                    0: ce_pct = 100;
                    1: ce_pct = 50;
                    default: ce_pct = 80;
                endcase
                start_pct = ($urandom_range(0, 1) == 0) ? 100 : 10;
            end
            @(negedge clk);
            check_outputs();
            #1;
            rst_n     = ($urandom_range(0, 399) != 0);
            start     = ($urandom_range(0, 99) < start_pct);
            ce        = ($urandom_range(0, 99) < ce_pct);
            y_in      = ($urandom_range(0, 1) == 0) ? tbl[$urandom_range(0, 4)] : W'($urandom);
            out_ready = rst_n && ($urandom_range(0, 99) < ready_pct);
            model_step();
        end

        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            check_outputs();
            #1;
            rst_n = 1'b1; start = 1'b0; ce = 1'b0; out_ready = 1'b1;
            model_step();
        end
        @(negedge clk);
        check_outputs();
        #3;
        check("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
